// File: rtl/mult_fu_if.sv
// -----------------------------------------------------------------------------
// mult_fu_pkg / mult_fu_if
//
// Purpose: shared packet types and the bundled port interface for the pipelined
// multiply functional unit (mult_fu).
//
// mult_fu_pkg:
//   reservation_station_s : operands vj/vk, op[1:0], dest (ROB entry)
//   cdb_packet_s          : valid, rob_entry, data
//
// mult_fu_if signals (names follow the unit's view of the world):
//   flush_i          : synchronous squash of in-flight and buffered results
//   execute_valid_i  : station presents an instruction
//   execute_packet_i : instruction payload
//   execute_tag_i    : RS tag, debug/trace only
//   fu_ready_o       : unit can accept an instruction this cycle
//   cdb_req_o        : output buffer non-empty
//   cdb_grant_i      : arbiter grants the CDB this cycle
//   cdb_packet_o     : CDB broadcast (head of output buffer)
//   busy_o           : any stage or buffer entry valid
//
// Modports: slave = the functional unit, master = station/arbiter side.
// -----------------------------------------------------------------------------
package mult_fu_pkg;

  typedef struct packed {
    logic [31:0] vj;
    logic [31:0] vk;
    logic [1:0]  op;
    logic [3:0]  dest;
  } reservation_station_s;

  typedef struct packed {
    logic        valid;
    logic [3:0]  rob_entry;
    logic [31:0] data;
  } cdb_packet_s;

endpackage

interface mult_fu_if;
  import mult_fu_pkg::*;

  logic                 flush_i;
  logic                 execute_valid_i;
  reservation_station_s execute_packet_i;
  logic [3:0]           execute_tag_i;
  logic                 fu_ready_o;
  logic                 cdb_req_o;
  logic                 cdb_grant_i;
  cdb_packet_s          cdb_packet_o;
  logic                 busy_o;

  modport slave (
    input  flush_i, execute_valid_i, execute_packet_i, execute_tag_i, cdb_grant_i,
    output fu_ready_o, cdb_req_o, cdb_packet_o, busy_o
  );

  modport master (
    output flush_i, execute_valid_i, execute_packet_i, execute_tag_i, cdb_grant_i,
    input  fu_ready_o, cdb_req_o, cdb_packet_o, busy_o
  );

endinterface

// File: rtl/mult_fu.sv
// -----------------------------------------------------------------------------
// mult_fu
//
// Purpose: pipelined 32x32 integer multiply unit. One instruction per cycle is
// accepted from the multiply reservation station, travels LATENCY stages, lands
// in a small in-order output buffer and is broadcast on the CDB through a
// request/grant handshake.
//
// Parameters:
//   LATENCY    : pipeline stages, 1..6 (default 3)
//   OBUF_DEPTH : output buffer entries, power of two 2..4 (default 2)
//
// Ports:
//   clk_i    : clock
//   reset_ni : asynchronous active-low reset
//   fu_if    : mult_fu_if.slave (execute handshake, CDB handshake, flush, busy)
//
// Configuration macro: MULT_FU_HIGH_EN
//   defined   : MUL / MULH / MULHSU / MULHU supported via op[1:0]
//   undefined : op ignored, only the low 32 bits of the product are produced
// -----------------------------------------------------------------------------
module mult_fu
  import mult_fu_pkg::*;
#(
  parameter int LATENCY    = 3,
  parameter int OBUF_DEPTH = 2
) (
  input logic      clk_i,
  input logic      reset_ni,
  mult_fu_if.slave fu_if
);

  localparam int PW = $clog2(OBUF_DEPTH);
  localparam int CW = PW + 1;

  // Pipeline stage state
  logic [LATENCY-1:0] stage_v_q, stage_v_d;
  logic [3:0]         stage_dest_q [LATENCY];
  logic [3:0]         stage_dest_d [LATENCY];
  logic [3:0]         stage_tag_q  [LATENCY];
  logic [3:0]         stage_tag_d  [LATENCY];
  logic [31:0]        stage_res_q  [LATENCY];
  logic [31:0]        stage_res_d  [LATENCY];

  // Output buffer state
  logic [3:0]         obuf_dest_q [OBUF_DEPTH];
  logic [31:0]        obuf_data_q [OBUF_DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;

  logic               obuf_full_s;
  logic               adv_s;
  logic               push_s;
  logic               pop_s;
  logic               req_s;
  logic [31:0]        prod_sel_s;
  cdb_packet_s        cdb_pkt_s;
  logic               dbg_unused_s;

  reservation_station_s pkt_s;
  assign pkt_s = fu_if.execute_packet_i;

  // ---------------------------------------------------------------------------
  // Stage-0 product
  // ---------------------------------------------------------------------------
`ifdef MULT_FU_HIGH_EN
  logic [32:0] opa_s, opb_s;
  logic [65:0] opa_ext_s, opb_ext_s, prod_full_s;

  // Sign/zero-extend operands to 33 bits so one signed multiplier covers all ops
  always_comb begin
    if (pkt_s.op == 2'b11) begin
      opa_s = {1'b0, pkt_s.vj};
    end else begin
      opa_s = {pkt_s.vj[31], pkt_s.vj};
    end
    if (pkt_s.op == 2'b01) begin
      opb_s = {pkt_s.vk[31], pkt_s.vk};
    end else begin
      opb_s = {1'b0, pkt_s.vk};
    end
    opa_ext_s   = {{33{opa_s[32]}}, opa_s};
    opb_ext_s   = {{33{opb_s[32]}}, opb_s};
    prod_full_s = opa_ext_s * opb_ext_s;
    case (pkt_s.op)
      2'b00:   prod_sel_s = prod_full_s[31:0];
      2'b01,
      2'b10,
      2'b11:   prod_sel_s = prod_full_s[63:32];
      default: prod_sel_s = prod_full_s[31:0];
    endcase
  end

  // Bits with no consumer (trace tag at the last stage, product sign bits)
  assign dbg_unused_s = ^{stage_tag_q[LATENCY-1], prod_full_s[65:64]};
`else
  // Low-half-only multiplier
  always_comb begin
    prod_sel_s = pkt_s.vj * pkt_s.vk;
  end

  // Bits with no consumer (trace tag at the last stage, ignored op)
  assign dbg_unused_s = ^{stage_tag_q[LATENCY-1], pkt_s.op};
`endif

  // ---------------------------------------------------------------------------
  // Handshake control. adv depends only on registered state, so fu_ready_o
  // never combinationally follows the arbiter grant.
  // ---------------------------------------------------------------------------
  assign obuf_full_s = (count_q == CW'(OBUF_DEPTH));
  assign adv_s       = !(stage_v_q[LATENCY-1] && obuf_full_s);
  assign req_s       = (count_q != {CW{1'b0}});
  assign push_s      = adv_s && stage_v_q[LATENCY-1];
  assign pop_s       = fu_if.cdb_grant_i && req_s;

  // Pipeline next state: flush clears, adv shifts, otherwise hold
  always_comb begin
    stage_v_d    = stage_v_q;
    stage_dest_d = stage_dest_q;
    stage_tag_d  = stage_tag_q;
    stage_res_d  = stage_res_q;
    if (fu_if.flush_i) begin
      stage_v_d = {LATENCY{1'b0}};
    end else if (adv_s) begin
      stage_v_d[0]    = fu_if.execute_valid_i;
      stage_dest_d[0] = pkt_s.dest;
      stage_tag_d[0]  = fu_if.execute_tag_i;
      stage_res_d[0]  = prod_sel_s;
      for (int i = 1; i < LATENCY; i++) begin
        stage_v_d[i]    = stage_v_q[i-1];
        stage_dest_d[i] = stage_dest_q[i-1];
        stage_tag_d[i]  = stage_tag_q[i-1];
        stage_res_d[i]  = stage_res_q[i-1];
      end
    end else begin
      stage_v_d = stage_v_q;
    end
  end

  // Stage valid bits
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      stage_v_q <= {LATENCY{1'b0}};
    end else begin
      stage_v_q <= stage_v_d;
    end
  end

  // Stage datapath (qualified by the valid bits, no reset needed)
  always_ff @(posedge clk_i) begin
    stage_dest_q <= stage_dest_d;
    stage_tag_q  <= stage_tag_d;
    stage_res_q  <= stage_res_d;
  end

  // Output buffer pointer/count next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fu_if.flush_i) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          wr_ptr_d = wr_ptr_q + PW'(1);
          count_d  = count_q + CW'(1);
        end
        2'b01: begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          count_d  = count_q - CW'(1);
        end
        2'b11: begin
          wr_ptr_d = wr_ptr_q + PW'(1);
          rd_ptr_d = rd_ptr_q + PW'(1);
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // Output buffer pointers and count
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Output buffer storage; reset to zero so the CDB packet is all-zero in reset
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        obuf_dest_q[i] <= 4'd0;
        obuf_data_q[i] <= 32'd0;
      end
    end else if (push_s && !fu_if.flush_i) begin
      obuf_dest_q[wr_ptr_q] <= stage_dest_q[LATENCY-1];
      obuf_data_q[wr_ptr_q] <= stage_res_q[LATENCY-1];
    end else begin
      obuf_dest_q <= obuf_dest_q;
      obuf_data_q <= obuf_data_q;
    end
  end

  // CDB packet: head of buffer, valid only when a request is granted
  always_comb begin
    cdb_pkt_s.valid     = req_s && fu_if.cdb_grant_i;
    cdb_pkt_s.rob_entry = obuf_dest_q[rd_ptr_q];
    cdb_pkt_s.data      = obuf_data_q[rd_ptr_q];
  end

  assign fu_if.fu_ready_o   = adv_s;
  assign fu_if.cdb_req_o    = req_s;
  assign fu_if.cdb_packet_o = cdb_pkt_s;
  assign fu_if.busy_o       = (|stage_v_q) || req_s;

endmodule

// File: tb/tb_mult_fu.sv
// -----------------------------------------------------------------------------
// tb_mult_fu: directed self-checking bench for mult_fu (LATENCY=3, OBUF_DEPTH=2).
// Cycles start one time unit after each rising edge; outputs are sampled a
// further one or more time units later, well clear of the clock edge.
// -----------------------------------------------------------------------------
module tb_mult_fu;
  import mult_fu_pkg::*;

  logic clk = 1'b0;
  logic reset_ni;

  mult_fu_if fu_if ();

  mult_fu #(.LATENCY(3), .OBUF_DEPTH(2)) dut (
    .clk_i   (clk),
    .reset_ni(reset_ni),
    .fu_if   (fu_if)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  int          exp_dest_q [$];
  logic [31:0] exp_data_q [$];

  logic [1:0]  sgn_op   [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
`ifdef MULT_FU_HIGH_EN
  logic [31:0] sgn_data [4] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
`else
  logic [31:0] sgn_data [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
`endif
  // (100+d)*d for d = 1..6
  logic [31:0] bp_data  [6] = '{32'd101, 32'd204, 32'd309, 32'd416, 32'd525, 32'd636};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic reservation_station_s mk_pkt(input logic [31:0] a, input logic [31:0] b,
                                                  input logic [1:0] op, input logic [3:0] d);
    reservation_station_s p;
    p.vj   = a;
    p.vk   = b;
    p.op   = op;
    p.dest = d;
    return p;
  endfunction

  // Drain the expected queue from the CDB, requiring back-to-back broadcasts
  task automatic collect(input string tag, input int budget);
    bit   started;
    logic acc;
    started = 1'b0;
    for (int c = 0; c < budget && exp_dest_q.size() > 0; c++) begin
      #1;
      if (started) chk({tag, "_contig"}, 64'(fu_if.cdb_packet_o.valid), 64'(1'b1));
      if (fu_if.cdb_packet_o.valid) begin
        started = 1'b1;
        chk({tag, "_dest"}, 64'(fu_if.cdb_packet_o.rob_entry), 64'(exp_dest_q[0]));
        chk({tag, "_data"}, 64'(fu_if.cdb_packet_o.data), 64'(exp_data_q[0]));
        void'(exp_dest_q.pop_front());
        void'(exp_data_q.pop_front());
      end
      acc = fu_if.execute_valid_i && fu_if.fu_ready_o;
      cyc();
      if (acc) fu_if.execute_valid_i = 1'b0;
    end
    chk({tag, "_pending"}, 64'(exp_dest_q.size()), 64'(0));
    exp_dest_q.delete();
    exp_data_q.delete();
  endtask

  initial begin
    int nxt;
    reset_ni               = 1'b0;
    fu_if.flush_i          = 1'b0;
    fu_if.execute_valid_i  = 1'b0;
    fu_if.execute_packet_i = '0;
    fu_if.execute_tag_i    = 4'd4;
    fu_if.cdb_grant_i      = 1'b0;

    // Reset values
    #2;
    chk("rst_ready", 64'(fu_if.fu_ready_o), 64'(1'b1));
    chk("rst_req",   64'(fu_if.cdb_req_o),  64'(1'b0));
    chk("rst_pkt",   64'(fu_if.cdb_packet_o), 64'(0));
    chk("rst_busy",  64'(fu_if.busy_o),     64'(1'b0));
    #5 reset_ni = 1'b1;
    cyc();

    // Basic MUL: 7*6 -> dest 3, request in cycle 4
    fu_if.cdb_grant_i      = 1'b1;
    fu_if.execute_valid_i  = 1'b1;
    fu_if.execute_packet_i = mk_pkt(32'd7, 32'd6, 2'b00, 4'd3);
    for (int k = 0; k <= 4; k++) begin
      #1;
      chk("basic_req", 64'(fu_if.cdb_req_o), 64'(k == 4));
      if (k == 4) begin
        chk("basic_valid", 64'(fu_if.cdb_packet_o.valid),     64'(1'b1));
        chk("basic_rob",   64'(fu_if.cdb_packet_o.rob_entry), 64'(3));
        chk("basic_data",  64'(fu_if.cdb_packet_o.data),      64'(42));
      end
      cyc();
      fu_if.execute_valid_i = 1'b0;
    end
    #1;
    chk("basic_idle", 64'(fu_if.busy_o), 64'(1'b0));
    cyc();

    // Signedness: 0xFFFFFFFF x 2 under each op
    for (int i = 0; i < 4; i++) begin
      fu_if.execute_valid_i  = 1'b1;
      fu_if.execute_packet_i = mk_pkt(32'hFFFF_FFFF, 32'd2, sgn_op[i], 4'(4 + i));
      #1;
      chk("sign_ready", 64'(fu_if.fu_ready_o), 64'(1'b1));
      exp_dest_q.push_back(4 + i);
      exp_data_q.push_back(sgn_data[i]);
      cyc();
    end
    fu_if.execute_valid_i = 1'b0;
    collect("sign", 20);

    // Backpressure: no grants, offer dest 1..6 back to back
    fu_if.cdb_grant_i = 1'b0;
    nxt = 1;
    for (int c = 0; c < 7; c++) begin
      fu_if.execute_valid_i  = 1'b1;
      fu_if.execute_packet_i = mk_pkt(32'(100 + nxt), 32'(nxt), 2'b00, 4'(nxt));
      #1;
      chk("bp_ready", 64'(fu_if.fu_ready_o), 64'(c < 5));
      if (fu_if.fu_ready_o) begin
        exp_dest_q.push_back(nxt);
        exp_data_q.push_back(bp_data[nxt-1]);
        nxt++;
      end
      cyc();
    end
    chk("bp_accepted", 64'(nxt), 64'(6));
    exp_dest_q.push_back(6);
    exp_data_q.push_back(bp_data[5]);
    fu_if.cdb_grant_i = 1'b1;
    collect("bp", 20);
    fu_if.execute_valid_i = 1'b0;

    // Flush: 1 buffered + 3 in flight, plus a dropped accept in the flush cycle
    fu_if.cdb_grant_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fu_if.execute_valid_i  = 1'b1;
      fu_if.execute_packet_i = mk_pkt(32'(i + 2), 32'd3, 2'b00, 4'(8 + i));
      cyc();
    end
    fu_if.execute_packet_i = mk_pkt(32'd9, 32'd9, 2'b00, 4'd12);
    fu_if.flush_i          = 1'b1;
    #1;
    chk("fl_req_before",  64'(fu_if.cdb_req_o), 64'(1'b1));
    chk("fl_busy_before", 64'(fu_if.busy_o),    64'(1'b1));
    cyc();
    fu_if.flush_i         = 1'b0;
    fu_if.execute_valid_i = 1'b0;
    #1;
    chk("fl_req",   64'(fu_if.cdb_req_o),  64'(1'b0));
    chk("fl_busy",  64'(fu_if.busy_o),     64'(1'b0));
    chk("fl_ready", 64'(fu_if.fu_ready_o), 64'(1'b1));
    // Spurious grants with empty buffer
    fu_if.cdb_grant_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("spur_valid", 64'(fu_if.cdb_packet_o.valid), 64'(1'b0));
      chk("spur_busy",  64'(fu_if.busy_o),             64'(1'b0));
      cyc();
    end

    // Async reset with a full buffer
    fu_if.cdb_grant_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      fu_if.execute_valid_i  = 1'b1;
      fu_if.execute_packet_i = mk_pkt(32'(i + 1), 32'd5, 2'b00, 4'(i + 1));
      cyc();
    end
    fu_if.execute_valid_i = 1'b0;
    #1;
    chk("ar_full_req",   64'(fu_if.cdb_req_o),  64'(1'b1));
    chk("ar_full_ready", 64'(fu_if.fu_ready_o), 64'(1'b0));
    fu_if.cdb_grant_i = 1'b1;
    #1;
    chk("ar_pre_valid", 64'(fu_if.cdb_packet_o.valid),     64'(1'b1));
    chk("ar_pre_rob",   64'(fu_if.cdb_packet_o.rob_entry), 64'(1));
    reset_ni = 1'b0;
    #1;
    chk("ar_ready", 64'(fu_if.fu_ready_o),   64'(1'b1));
    chk("ar_req",   64'(fu_if.cdb_req_o),    64'(1'b0));
    chk("ar_pkt",   64'(fu_if.cdb_packet_o), 64'(0));
    chk("ar_busy",  64'(fu_if.busy_o),       64'(1'b0));
    cyc();
    reset_ni = 1'b1;
    cyc();

    // Post-reset operation, including low-half truncation
    fu_if.execute_valid_i  = 1'b1;
    fu_if.execute_packet_i = mk_pkt(32'h0001_2345, 32'h0000_0100, 2'b00, 4'd12);
    exp_dest_q.push_back(12);
    exp_data_q.push_back(32'h0123_4500);
    cyc();
    fu_if.execute_packet_i = mk_pkt(32'h8000_0000, 32'd3, 2'b00, 4'd13);
    exp_dest_q.push_back(13);
    exp_data_q.push_back(32'h8000_0000);
    cyc();
    fu_if.execute_valid_i = 1'b0;
    collect("post", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_fu.md
# mult_fu

Pipelined integer multiply functional unit that sits directly downstream of the multiply reservation station (tags 4–7). It accepts one ready instruction per cycle from the station's execute interface and computes the 32×32 product over `LATENCY` pipeline stages. Completed results are held in a small output buffer and broadcast on the common data bus (CDB) through a request/grant handshake with the CDB arbiter. Completed results are in order with respect to issue into this unit.

## Interface

**Parameters**

- `LATENCY`, default 3: number of pipeline stages, 1..6.
- `OBUF_DEPTH`, default 2: output buffer entries, power of two, 2..4.

**Ports**

- `clk_i` in 1: clock.
- `reset_ni` in 1: asynchronous, active-low reset.
- `flush_i` in 1: synchronous squash of all in-flight and buffered results.
- `execute_valid_i` in 1: the station presents an instruction.
- `execute_packet_i` in `reservation_station_s`:
  - fields used: `vj`, `vk` (32-bit operands), `op[1:0]`, `dest` (4-bit ROB entry).
- `execute_tag_i` in 4: RS tag, carried for debug and trace only.
- `fu_ready_o` out 1: the unit can accept an instruction this cycle.
- `cdb_req_o` out 1: the output buffer is non-empty.
- `cdb_grant_i` in 1: the arbiter grants the CDB this cycle.
- `cdb_packet_o` out `cdb_packet_s`:
  - `valid`, `rob_entry`, `data` (32-bit).
- `busy_o` out 1: any stage or buffer entry is valid.

## Operation

- **Op encoding:**
  - 00 MUL: low 32 bits.
  - 01 MULH: signed×signed, high 32 bits.
  - 10 MULHSU: signed `vj` × unsigned `vk`, high 32 bits.
  - 11 MULHU: unsigned×unsigned, high 32 bits.
- **Product width:** the full product is computed as 64 bits in stage 0 using 33-bit sign/zero-extended operands. The selected 32-bit half and `dest` travel through stages 1..LATENCY-1.
- **Accept:** an instruction enters stage 0 when `execute_valid_i && fu_ready_o`.
- **Pipeline state:** each stage holds valid, dest, tag and result.
- **Advance condition:** `adv = !(stage_v[LATENCY-1] && obuf_full)`.
  - When `adv` is high, all stages shift by one.
  - When `adv` is low, the whole pipeline holds.
- **Ready:** `fu_ready_o = adv`.
  - It is a function of registered state only; it never depends on `cdb_grant_i`. This avoids a combinational path through the arbiter.
- **Output buffer:** circular FIFO.
  - Push on `adv && stage_v[LATENCY-1]`.
  - Pop on `cdb_grant_i && cdb_req_o`.
  - Simultaneous push and pop while full cannot occur, because `adv` is low when full.
  - Simultaneous push and pop in any other state keeps the count unchanged.
  - Read and write pointers wrap modulo `OBUF_DEPTH`. The count is `$clog2(OBUF_DEPTH)+1` bits wide.
- **CDB output:**
  - `cdb_packet_o.valid = cdb_req_o && cdb_grant_i`.
  - `rob_entry` and `data` always reflect the buffer head.
  - A grant while the buffer is empty is ignored.
- **Flush:** `flush_i` has priority over accept, shift, push and pop.
  - All stage valids and the buffer count clear at the edge.
  - `fu_ready_o` is high in the next cycle.
  - An accept in the same cycle as a flush is dropped.
- **Reset:** asserting `reset_ni` low clears the same state asynchronously, including mid-operation. Datapath registers need not reset.

## Timing

- **Reset values:**
  - `fu_ready_o` = 1.
  - `cdb_req_o` = 0.
  - `cdb_packet_o` = all zeros.
  - `busy_o` = 0.
- **Latency:** an instruction accepted in cycle 0 sits in stage k after edge k. It reaches the buffer after edge LATENCY, and `cdb_req_o` rises in cycle LATENCY+1 (cycle 4 at the default).
- **Throughput:** one instruction per cycle while the CDB grants every cycle.
- **Backpressure:** with no grants, the unit accepts `LATENCY+OBUF_DEPTH` instructions (5 at the defaults), then `fu_ready_o` falls. It rises again in the cycle after the first pop.
- **Ordering:** results leave in accept order.

## Configuration

- **`MULT_FU_HIGH_EN` defined:** all four ops are supported as described above.
- **`MULT_FU_HIGH_EN` undefined:**
  - `op` is ignored and every instruction returns the low 32 bits.
  - The 33-bit extension logic is removed; stage 0 computes only a 32×32→32 product.

## Test plan

- **Basic MUL:** `vj`=7, `vk`=6, op=00, `dest`=3 accepted in cycle 0 with grant held high → `cdb_req_o` rises in cycle 4; `cdb_packet_o` = {valid 1, rob_entry 3, data 42}.
- **Signedness:** with the macro defined, `vj`=0xFFFFFFFF, `vk`=2:
  - op 01 → 0xFFFFFFFF.
  - op 11 → 0x00000001.
  - op 10 → 0xFFFFFFFF.
  - op 00 → 0xFFFFFFFE.
  - Without the macro, all four return 0xFFFFFFFE.
- **Backpressure:** grant held low while 6 back-to-back instructions are offered with `dest` 1..6 → 5 accepted, `fu_ready_o` low from cycle 5. Then raise grant → results for `dest` 1..6 are broadcast in order, one per cycle.
- **Flush:** 3 instructions in flight and 1 buffered, then `flush_i` pulsed → `cdb_req_o` is 0 and `busy_o` is 0 the next cycle, with no CDB packet for any of the four.
- **Async reset:** drive `reset_ni` low mid-cycle while the buffer is full → outputs go to their reset values immediately, without waiting for a clock edge.
- **Spurious grant:** `cdb_grant_i`=1 while the buffer is empty → `cdb_packet_o.valid` stays 0 and the buffer count stays 0.
